imem_loader_dp: RTL and testbench

- Parametrised next-generation instruction memory. One write port is driven by a burst loader FSM, and one independent read port serves the decoder.
- The loader accepts a base address and a word count, then streams instruction words in with a valid/ready handshake, auto-incrementing the address.
- The read port has configurable latency, an explicit valid flag, and write-first forwarding from the write pipeline stage.
- Sits between the host/DMA instruction feed and the decoder.

---
 rtl/imem_loader_dp.sv | 163 ++++++++++++++++
 tb/tb_imem_loader_dp.sv | 357 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/imem_loader_dp.sv
// Instruction memory with a burst loader on the write port and a
// pipelined, write-first-forwarding read port for the decoder.
module imem_loader_dp #(
  parameter int unsigned DATA_WIDTH   = 32,
  parameter int unsigned SIZE_IN_BITS = 1 << 14,
  parameter int unsigned ADDR_WIDTH   = $clog2(SIZE_IN_BITS / DATA_WIDTH),
  parameter int unsigned READ_LATENCY = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  i_load_start,
  input  logic [ADDR_WIDTH-1:0] i_load_base_addr,
  input  logic [ADDR_WIDTH:0]   i_load_len,
  input  logic                  i_load_valid,
  input  logic [DATA_WIDTH-1:0] i_load_data,
  output logic                  o_load_ready,
  output logic                  o_load_busy,
  output logic                  o_load_done,
  input  logic                  i_read_req,
  input  logic [ADDR_WIDTH-1:0] i_read_addr,
  output logic                  o_read_valid,
  output logic [DATA_WIDTH-1:0] o_read_data
);

  localparam int unsigned DEPTH     = SIZE_IN_BITS / DATA_WIDTH;
  localparam int unsigned LEN_WIDTH = ADDR_WIDTH + 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
  logic [LEN_WIDTH-1:0]  remaining_q, remaining_d;
  logic                  beat_c;

  logic                  ws_valid_q;
  logic [ADDR_WIDTH-1:0] ws_addr_q;
  logic [DATA_WIDTH-1:0] ws_data_q;

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic                  rd_valid_q;
  logic [DATA_WIDTH-1:0] rd_data_q;

  assign beat_c = i_load_valid & o_load_ready;

  // Loader state, pointers and registered handshake/status outputs
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      wr_ptr_q     <= '0;
      remaining_q  <= '0;
      o_load_ready <= 1'b0;
      o_load_busy  <= 1'b0;
      o_load_done  <= 1'b0;
    end else begin
      state_q      <= state_d;
      wr_ptr_q     <= wr_ptr_d;
      remaining_q  <= remaining_d;
      o_load_ready <= (state_d == LOAD);
      o_load_busy  <= (state_d != IDLE);
      o_load_done  <= (state_d == DONE);
    end
  end

  // Loader next-state: latch burst, count beats, pulse done
  always_comb begin
    state_d     = state_q;
    wr_ptr_d    = wr_ptr_q;
    remaining_d = remaining_q;
    case (state_q)
      IDLE: begin
        if (i_load_start) begin
          if (i_load_len != '0) begin
            wr_ptr_d    = i_load_base_addr;
            remaining_d = i_load_len;
            state_d     = LOAD;
          end else begin
            state_d = DONE;
          end
        end
      end
      LOAD: begin
        if (beat_c) begin
          wr_ptr_d    = wr_ptr_q + ADDR_WIDTH'(1);
          remaining_d = remaining_q - LEN_WIDTH'(1);
          if (remaining_q == LEN_WIDTH'(1)) begin
            state_d = DONE;
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // One-deep write stage between the loader beat and the array
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ws_valid_q <= 1'b0;
      ws_addr_q  <= '0;
      ws_data_q  <= '0;
    end else begin
      ws_valid_q <= beat_c;
      if (beat_c) begin
        ws_addr_q <= wr_ptr_q;
        ws_data_q <= i_load_data;
      end
    end
  end

  // Storage array; contents survive reset
  always_ff @(posedge clk) begin
    if (ws_valid_q) begin
      mem[ws_addr_q] <= ws_data_q;
    end
  end

  // First read stage with write-first forwarding from the write stage
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_valid_q <= 1'b0;
      rd_data_q  <= '0;
    end else begin
      rd_valid_q <= i_read_req;
      if (i_read_req) begin
        if (ws_valid_q && (ws_addr_q == i_read_addr)) begin
          rd_data_q <= ws_data_q;
        end else begin
          rd_data_q <= mem[i_read_addr];
        end
      end
    end
  end

  if (READ_LATENCY == 2) begin : g_lat2
    logic                  rd2_valid_q;
    logic [DATA_WIDTH-1:0] rd2_data_q;

    // Extra output register stage; data holds when nothing new arrives
    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        rd2_valid_q <= 1'b0;
        rd2_data_q  <= '0;
      end else begin
        rd2_valid_q <= rd_valid_q;
        if (rd_valid_q) begin
          rd2_data_q <= rd_data_q;
        end
      end
    end

    assign o_read_valid = rd2_valid_q;
    assign o_read_data  = rd2_data_q;
  end else begin : g_lat1
    assign o_read_valid = rd_valid_q;
    assign o_read_data  = rd_data_q;
  end

endmodule

// File: tb/tb_imem_loader_dp.sv
// Scoreboarded bench for imem_loader_dp at read latencies 1 and 2.
module tb_imem_loader_dp;

  localparam int unsigned DW    = 32;
  localparam int unsigned SIZE  = 1 << 14;
  localparam int unsigned DEPTH = SIZE / DW;
  localparam int unsigned AW    = $clog2(DEPTH);
  localparam int unsigned LW    = AW + 1;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          i_load_start = 1'b0;
  logic [AW-1:0] i_load_base_addr = '0;
  logic [AW:0]   i_load_len = '0;
  logic          i_load_valid = 1'b0;
  logic [DW-1:0] i_load_data = '0;
  logic          i_read_req = 1'b0;
  logic [AW-1:0] i_read_addr = '0;

  logic          rdy1, busy1, done1, rv1;
  logic [DW-1:0] rd1;
  logic          rdy2, busy2, done2, rv2;
  logic [DW-1:0] rd2;

  imem_loader_dp #(.DATA_WIDTH(DW), .SIZE_IN_BITS(SIZE), .READ_LATENCY(1)) dut1 (
    .clk(clk), .reset(reset),
    .i_load_start(i_load_start), .i_load_base_addr(i_load_base_addr),
    .i_load_len(i_load_len), .i_load_valid(i_load_valid), .i_load_data(i_load_data),
    .o_load_ready(rdy1), .o_load_busy(busy1), .o_load_done(done1),
    .i_read_req(i_read_req), .i_read_addr(i_read_addr),
    .o_read_valid(rv1), .o_read_data(rd1)
  );

  imem_loader_dp #(.DATA_WIDTH(DW), .SIZE_IN_BITS(SIZE), .READ_LATENCY(2)) dut2 (
    .clk(clk), .reset(reset),
    .i_load_start(i_load_start), .i_load_base_addr(i_load_base_addr),
    .i_load_len(i_load_len), .i_load_valid(i_load_valid), .i_load_data(i_load_data),
    .o_load_ready(rdy2), .o_load_busy(busy2), .o_load_done(done2),
    .i_read_req(i_read_req), .i_read_addr(i_read_addr),
    .o_read_valid(rv2), .o_read_data(rd2)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0;
  int bad = 0;

  // Reference memory image and which words it knows
  logic [DW-1:0] model [DEPTH];
  bit            known [DEPTH];
  int            bptr = 0;

  typedef struct {
    int            cyc;
    logic [DW-1:0] data;
    bit            chk;
  } sb_t;

  sb_t q1[$];
  sb_t q2[$];
  sb_t m1, m2;

  // Latency-1 read checker
  always @(negedge clk) begin
    if (q1.size() > 0 && q1[0].cyc < cyc) begin
      total++; bad++;
      $display("FAIL rd_missing_lat1: no valid at cyc %0d, required one", q1[0].cyc);
      q1.delete(0);
    end
    if (rv1) begin
      total++;
      if (q1.size() == 0) begin
        bad++;
        $display("FAIL rd_spurious_lat1: valid=1 at cyc %0d, required 0", cyc);
      end else begin
        m1 = q1.pop_front();
        if (m1.cyc != cyc) begin
          bad++;
          $display("FAIL rd_timing_lat1: valid at cyc %0d, required cyc %0d", cyc, m1.cyc);
        end else if ($isunknown(rd1)) begin
          bad++;
          $display("FAIL rd_x_lat1: data=%h, required no X", rd1);
        end else if (m1.chk && rd1 !== m1.data) begin
          bad++;
          $display("FAIL rd_data_lat1: got %h, required %h", rd1, m1.data);
        end
      end
    end
  end

  // Latency-2 read checker
  always @(negedge clk) begin
    if (q2.size() > 0 && q2[0].cyc < cyc) begin
      total++; bad++;
      $display("FAIL rd_missing_lat2: no valid at cyc %0d, required one", q2[0].cyc);
      q2.delete(0);
    end
    if (rv2) begin
      total++;
      if (q2.size() == 0) begin
        bad++;
        $display("FAIL rd_spurious_lat2: valid=1 at cyc %0d, required 0", cyc);
      end else begin
        m2 = q2.pop_front();
        if (m2.cyc != cyc) begin
          bad++;
          $display("FAIL rd_timing_lat2: valid at cyc %0d, required cyc %0d", cyc, m2.cyc);
        end else if ($isunknown(rd2)) begin
          bad++;
          $display("FAIL rd_x_lat2: data=%h, required no X", rd2);
        end else if (m2.chk && rd2 !== m2.data) begin
          bad++;
          $display("FAIL rd_data_lat2: got %h, required %h", rd2, m2.data);
        end
      end
    end
  end

  task automatic expect_read(input logic [DW-1:0] d, input bit chk);
    sb_t e;
    e.data = d;
    e.chk  = chk;
    e.cyc  = cyc + 1;
    q1.push_back(e);
    e.cyc  = cyc + 2;
    q2.push_back(e);
  endtask

  task automatic rd(input int a);
    expect_read(model[a], known[a]);
    i_read_req  = 1'b1;
    i_read_addr = AW'(a);
    @(negedge clk);
    i_read_req  = 1'b0;
  endtask

  task automatic start_burst(input int base, input int len);
    i_load_start     = 1'b1;
    i_load_base_addr = AW'(base);
    i_load_len       = LW'(len);
    if (len != 0) bptr = base;
    @(negedge clk);
    i_load_start = 1'b0;
  endtask

  task automatic send_beat(input logic [DW-1:0] data);
    int w = 0;
    while (!rdy1 && w < 16) begin
      @(negedge clk);
      w++;
    end
    total++;
    if (!rdy1) begin
      bad++;
      $display("FAIL beat_ready: ready=%b, required 1", rdy1);
    end
    i_load_valid = 1'b1;
    i_load_data  = data;
    model[bptr]  = data;
    known[bptr]  = 1'b1;
    bptr         = (bptr + 1) % DEPTH;
    @(negedge clk);
    i_load_valid = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    repeat (5) begin
      @(negedge clk);
      total++;
      if ({rdy1, busy1, done1, rv1, rv2} !== 5'b0) begin
        bad++;
        $display("FAIL reset_idle: rdy/busy/done/rv1/rv2=%b, required 00000",
                 {rdy1, busy1, done1, rv1, rv2});
      end
    end
    total++;
    if (rd1 !== '0 || rd2 !== '0) begin
      bad++;
      $display("FAIL reset_rdata: rd1=%h rd2=%h, required 0", rd1, rd2);
    end
    rd(3);
    repeat (3) @(negedge clk);
  endtask

  task automatic test_burst_gaps();
    start_burst(4, 3);
    total++;
    if (busy1 !== 1'b1 || rdy1 !== 1'b1) begin
      bad++;
      $display("FAIL burst_start: busy=%b ready=%b, required 1 1", busy1, rdy1);
    end
    send_beat(32'hA0);
    total++;
    if (done1 !== 1'b0) begin
      bad++;
      $display("FAIL burst_early_done1: done=%b, required 0", done1);
    end
    @(negedge clk);
    send_beat(32'hA1);
    total++;
    if (done1 !== 1'b0) begin
      bad++;
      $display("FAIL burst_early_done2: done=%b, required 0", done1);
    end
    @(negedge clk);
    send_beat(32'hA2);
    total++;
    if (done1 !== 1'b1 || busy1 !== 1'b1 || rdy1 !== 1'b0) begin
      bad++;
      $display("FAIL burst_done: done/busy/ready=%b%b%b, required 110", done1, busy1, rdy1);
    end
    @(negedge clk);
    total++;
    if (done1 !== 1'b0 || busy1 !== 1'b0) begin
      bad++;
      $display("FAIL burst_idle: done/busy=%b%b, required 00", done1, busy1);
    end
    rd(4); rd(5); rd(6);
    repeat (4) @(negedge clk);
  endtask

  task automatic test_wrap();
    start_burst(DEPTH - 2, 4);
    for (int i = 1; i <= 4; i++) send_beat(DW'(i));
    total++;
    if (done1 !== 1'b1) begin
      bad++;
      $display("FAIL wrap_done: done=%b, required 1", done1);
    end
    @(negedge clk);
    rd(DEPTH - 2); rd(DEPTH - 1); rd(0); rd(1);
    repeat (4) @(negedge clk);
  endtask

  task automatic test_forwarding();
    start_burst(9, 1);
    send_beat(32'h11);
    repeat (3) @(negedge clk);
    start_burst(9, 1);
    // Read on the beat cycle sees the old word
    i_load_valid = 1'b1;
    i_load_data  = 32'h55;
    i_read_req   = 1'b1;
    i_read_addr  = AW'(9);
    expect_read(32'h11, 1'b1);
    @(negedge clk);
    // Read on the commit cycle sees the forwarded word
    i_load_valid = 1'b0;
    model[9]     = 32'h55;
    expect_read(32'h55, 1'b1);
    @(negedge clk);
    i_read_req = 1'b0;
    repeat (2) @(negedge clk);
    rd(9); rd(4);
    repeat (4) @(negedge clk);
  endtask

  task automatic test_zero_len_ignore();
    start_burst(5, 0);
    total++;
    if (done1 !== 1'b1 || busy1 !== 1'b1 || rdy1 !== 1'b0) begin
      bad++;
      $display("FAIL zero_len_done: done/busy/ready=%b%b%b, required 110", done1, busy1, rdy1);
    end
    @(negedge clk);
    total++;
    if (done1 !== 1'b0 || busy1 !== 1'b0) begin
      bad++;
      $display("FAIL zero_len_idle: done/busy=%b%b, required 00", done1, busy1);
    end
    rd(5);
    repeat (3) @(negedge clk);
    start_burst(30, 2);
    i_load_start     = 1'b1;
    i_load_base_addr = AW'(4);
    i_load_len       = LW'(1);
    send_beat(32'h71);
    send_beat(32'h72);
    i_load_start = 1'b0;
    total++;
    if (done1 !== 1'b1) begin
      bad++;
      $display("FAIL ignore_done: done=%b, required 1", done1);
    end
    @(negedge clk);
    total++;
    if (busy1 !== 1'b0 || done1 !== 1'b0) begin
      bad++;
      $display("FAIL ignore_idle: busy/done=%b%b, required 00", busy1, done1);
    end
    rd(30); rd(31); rd(4);
    repeat (4) @(negedge clk);
  endtask

  task automatic test_reset_mid_burst();
    start_burst(50, 5);
    for (int i = 0; i < 5; i++) send_beat(DW'(32'hC0 + i));
    repeat (3) @(negedge clk);
    start_burst(50, 5);
    send_beat(32'hB0);
    send_beat(32'hB1);
    reset = 1'b0;
    model[51] = 32'hC1;
    #1;
    total++;
    if ({busy1, rdy1, done1} !== 3'b000) begin
      bad++;
      $display("FAIL midreset_async: busy/ready/done=%b%b%b, required 000", busy1, rdy1, done1);
    end
    @(negedge clk);
    reset = 1'b1;
    repeat (4) begin
      @(negedge clk);
      total++;
      if (done1 !== 1'b0 || busy1 !== 1'b0) begin
        bad++;
        $display("FAIL midreset_idle: done/busy=%b%b, required 00", done1, busy1);
      end
    end
    rd(50); rd(51); rd(52); rd(4);
    repeat (4) @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < DEPTH; i++) begin
      model[i] = '0;
      known[i] = 1'b0;
    end
    test_reset();
    test_burst_gaps();
    test_wrap();
    test_forwarding();
    test_zero_len_ignore();
    test_reset_mid_burst();
    repeat (5) @(negedge clk);
    total++;
    if (q1.size() != 0 || q2.size() != 0) begin
      bad++;
      $display("FAIL sb_drain: pending lat1=%0d lat2=%0d, required 0 0", q1.size(), q2.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
